// File: rtl/snn_pkg.sv
// ============================================================================
// Module      : snn_pkg
// Description : Shared state encodings and defaults for the spike-rate path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_WIN_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    HOLD  = 2'b10,
    BAD   = 2'b11
  } state_e;

  // Reported interval when a window saw fewer than two spikes
  localparam logic [DEF_WIN_W-1:0] ISI_NONE = '1;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all ones; clear has priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         sat_flag_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && !sat_flag_o) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o    = count_q;
  assign sat_flag_o = &count_q;

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
// ============================================================================
// Module      : spike_rate_decoder
// Description : Counts spikes over a latched window and reports the rate over
//               a valid/ready handshake. SPIKE_ISI_EN adds isi_min tracking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WIN_W = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIN_W-1:0] window_len,
  input  logic             spike_in,
  output logic [WIDTH-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overflow,
  output logic [1:0]       state_dbg
`ifdef SPIKE_ISI_EN
  ,
  output logic [WIN_W-1:0] isi_min
`endif
);

  state_e           state_q;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic             ovf_q;

  logic [WIDTH-1:0] spike_cnt;
  logic [WIDTH-1:0] final_cnt_d;
  logic             spike_sat;
  logic             counting;
  logic             spike_acc;
  logic             ovf_d;
  logic             last_sample;
  logic             done;
  logic             start_ok;

  assign counting    = (state_q == COUNT);
  assign spike_acc   = counting & spike_in;
  assign start_ok    = enable && (window_len != '0);
  assign last_sample = (win_cnt_q == win_len_q - WIN_W'(1));
  assign done        = counting & enable & last_sample;

  // Counter is held clear outside COUNT so every window starts from zero
  sat_counter #(.W(WIDTH)) u_spike_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (!counting),
    .inc_i      (spike_acc),
    .count_o    (spike_cnt),
    .sat_flag_o (spike_sat)
  );

  assign final_cnt_d = (spike_acc && !spike_sat) ? spike_cnt + WIDTH'(1) : spike_cnt;
  assign ovf_d       = ovf_q | (spike_acc & spike_sat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      win_len_q  <= '0;
      win_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      rate_out   <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            win_len_q <= window_len;
            win_cnt_q <= '0;
            ovf_q     <= 1'b0;
            state_q   <= COUNT;
          end
        end
        COUNT: begin
          if (!enable) begin
            state_q <= IDLE;
          end else if (last_sample) begin
            rate_out   <= final_cnt_d;
            overflow   <= ovf_d;
            rate_valid <= 1'b1;
            state_q    <= HOLD;
          end else begin
            win_cnt_q <= win_cnt_q + WIN_W'(1);
            ovf_q     <= ovf_d;
          end
        end
        HOLD: begin
          if (rate_ready) begin
            rate_valid <= 1'b0;
            if (start_ok) begin
              win_len_q <= window_len;
              win_cnt_q <= '0;
              ovf_q     <= 1'b0;
              state_q   <= COUNT;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_dbg = state_q;

`ifdef SPIKE_ISI_EN
  localparam logic [WIN_W-1:0] C_ISI_NONE = '1;

  logic [WIN_W-1:0] gap_cnt;
  logic [WIN_W-1:0] gap;
  logic [WIN_W-1:0] isi_run_q;
  logic [WIN_W-1:0] isi_run_d;
  logic             gap_sat;
  logic             seen_q;

  // gap_cnt holds the spike-free samples since the last spike
  sat_counter #(.W(WIN_W)) u_gap_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (!counting | spike_in),
    .inc_i      (counting & ~spike_in),
    .count_o    (gap_cnt),
    .sat_flag_o (gap_sat)
  );

  assign gap       = gap_sat ? gap_cnt : gap_cnt + WIN_W'(1);
  assign isi_run_d = (spike_acc && seen_q && (gap < isi_run_q)) ? gap : isi_run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q    <= 1'b0;
      isi_run_q <= C_ISI_NONE;
      isi_min   <= C_ISI_NONE;
    end else if (!counting) begin
      seen_q    <= 1'b0;
      isi_run_q <= C_ISI_NONE;
    end else begin
      seen_q    <= seen_q | spike_in;
      isi_run_q <= isi_run_d;
      if (done) begin
        isi_min <= isi_run_d;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_decoder.sv
// ============================================================================
// Module      : tb_spike_rate_decoder
// Description : Scoreboard bench for spike_rate_decoder (WIDTH=4, WIN_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_rate_decoder;

  localparam int W  = 4;
  localparam int WW = 8;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          enable     = 1'b0;
  logic          spike_in   = 1'b0;
  logic          rate_ready = 1'b0;
  logic [WW-1:0] window_len = '0;
  logic [W-1:0]  rate_out;
  logic          rate_valid;
  logic          overflow;
  logic [1:0]    state_dbg;
`ifdef SPIKE_ISI_EN
  logic [WW-1:0] isi_min;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0]  rate;
    logic          ovf;
    logic [WW-1:0] isi;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  spike_rate_decoder #(.WIDTH(W), .WIN_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .window_len (window_len),
    .spike_in   (spike_in),
    .rate_out   (rate_out),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .overflow   (overflow),
    .state_dbg  (state_dbg)
`ifdef SPIKE_ISI_EN
    ,
    .isi_min    (isi_min)
`endif
  );

  // Reference model: count, saturation, minimum spacing of a spike pattern
  task automatic push_expected(input int len, input logic [31:0] pat);
    exp_t e;
    int   n    = 0;
    int   prev = -1;
    int   mn   = 255;
    for (int i = 0; i < len; i++) begin
      if (pat[i]) begin
        if (prev >= 0 && (i - prev) < mn) mn = i - prev;
        prev = i;
        n++;
      end
    end
    e.rate = (n > 15) ? 4'hF : W'(n);
    e.ovf  = (n > 15);
    e.isi  = WW'(mn);
    sb.push_back(e);
  endtask

  // Drives one window's samples; the caller has the DUT in COUNT already
  task automatic drive_samples(input int len, input logic [31:0] pat);
    push_expected(len, pat);
    for (int i = 0; i < len; i++) begin
      spike_in = pat[i];
      if (i == 1) window_len = window_len ^ 8'h5A;
      @(negedge clk);
    end
    spike_in = 1'b0;
  endtask

  task automatic sb_drain(input string name);
    exp_t e;
    int   budget = 0;
    while (!rate_valid && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    n_checks++;
    if (rate_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: rate_valid=%b required 1", name, rate_valid);
      return;
    end
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s unexpected result: rate_out=%0d with empty scoreboard", name, rate_out);
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if (rate_out !== e.rate) begin
      n_fail++;
      $display("FAIL %s rate_out: got %0d required %0d", name, rate_out, e.rate);
    end
    n_checks++;
    if (overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL %s overflow: got %b required %b", name, overflow, e.ovf);
    end
`ifdef SPIKE_ISI_EN
    n_checks++;
    if (isi_min !== e.isi) begin
      n_fail++;
      $display("FAIL %s isi_min: got %0d required %0d", name, isi_min, e.isi);
    end
`endif
  endtask

  task automatic handshake_to_idle();
    enable     = 1'b0;
    rate_ready = 1'b1;
    @(negedge clk);
    rate_ready = 1'b0;
    n_checks++;
    if (rate_valid !== 1'b0 || state_dbg !== 2'b00) begin
      n_fail++;
      $display("FAIL handshake: rate_valid=%b state=%b required 0/00", rate_valid, state_dbg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'b00 || rate_valid !== 1'b0 || rate_out !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%b valid=%b rate=%0d ovf=%b required 00/0/0/0", state_dbg, rate_valid, rate_out, overflow);
    end
`ifdef SPIKE_ISI_EN
    n_checks++;
    if (isi_min !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset isi_min: got %0d required 255", isi_min);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    enable     = 1'b1;
    window_len = 8'd10;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'b01) begin
      n_fail++;
      $display("FAIL basic start: state=%b required 01", state_dbg);
    end
    drive_samples(10, 32'h0000_0224);
    n_checks++;
    if (rate_valid !== 1'b1 || state_dbg !== 2'b10) begin
      n_fail++;
      $display("FAIL basic latency: valid=%b state=%b required 1/10", rate_valid, state_dbg);
    end
    sb_drain("basic");
  endtask

  task automatic test_backpressure();
    rate_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      spike_in = i[0];
      @(negedge clk);
      n_checks++;
      if (rate_valid !== 1'b1 || rate_out !== 4'd3) begin
        n_fail++;
        $display("FAIL backpressure hold cycle %0d: valid=%b rate=%0d required 1/3", i, rate_valid, rate_out);
      end
    end
    window_len = 8'd10;
    enable     = 1'b1;
    rate_ready = 1'b1;
    spike_in   = 1'b1;
    @(negedge clk);
    rate_ready = 1'b0;
    n_checks++;
    if (rate_valid !== 1'b0 || state_dbg !== 2'b01) begin
      n_fail++;
      $display("FAIL backpressure restart: valid=%b state=%b required 0/01", rate_valid, state_dbg);
    end
    drive_samples(10, 32'h0000_0200);
    sb_drain("backpressure_next");
    handshake_to_idle();
  endtask

  task automatic test_abort();
    enable     = 1'b1;
    window_len = 8'd10;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      spike_in = 1'b1;
      @(negedge clk);
    end
    enable   = 1'b0;
    spike_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_dbg !== 2'b00 || rate_valid !== 1'b0 || rate_out !== 4'd1) begin
      n_fail++;
      $display("FAIL abort: state=%b valid=%b rate=%0d required 00/0/1", state_dbg, rate_valid, rate_out);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (rate_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort quiet cycle %0d: rate_valid=%b required 0", i, rate_valid);
      end
    end
  endtask

  task automatic test_saturation();
    enable     = 1'b1;
    window_len = 8'd20;
    @(negedge clk);
    drive_samples(20, 32'h000F_FFFF);
    n_checks++;
    if (rate_valid !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL saturation: valid=%b overflow=%b required 1/1", rate_valid, overflow);
    end
    sb_drain("saturation");
    window_len = 8'd20;
    rate_ready = 1'b1;
    @(negedge clk);
    rate_ready = 1'b0;
    drive_samples(20, 32'h0);
    sb_drain("saturation_clean");
    handshake_to_idle();
  endtask

  task automatic test_window_edges();
    enable     = 1'b1;
    window_len = 8'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (state_dbg !== 2'b00 || rate_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero window cycle %0d: state=%b valid=%b required 00/0", i, state_dbg, rate_valid);
      end
    end
    window_len = 8'd1;
    @(negedge clk);
    drive_samples(1, 32'h1);
    n_checks++;
    if (rate_valid !== 1'b1 || rate_out !== 4'd1) begin
      n_fail++;
      $display("FAIL one-sample window: valid=%b rate=%0d required 1/1", rate_valid, rate_out);
    end
    sb_drain("one_sample");
    handshake_to_idle();
  endtask

  task automatic test_async_reset();
    enable     = 1'b1;
    window_len = 8'd10;
    @(negedge clk);
    spike_in = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (state_dbg !== 2'b00 || rate_valid !== 1'b0 || rate_out !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: state=%b valid=%b rate=%0d ovf=%b required 00/0/0/0", state_dbg, rate_valid, rate_out, overflow);
    end
    @(negedge clk);
    rst      = 1'b0;
    enable   = 1'b0;
    spike_in = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (rate_valid !== 1'b0 || state_dbg !== 2'b00) begin
      n_fail++;
      $display("FAIL after reset: valid=%b state=%b required 0/00", rate_valid, state_dbg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_saturation();
    test_window_edges();
    test_async_reset();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard: %0d results never produced, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
